// File: rtl/param_stream_ctrl.sv
// Parameter ROM sequencer: issues addresses, tags reads in flight and streams words through a small FIFO.
// First word valid READ_LATENCY+2 cycles after start; issue is gated by a credit count so stalls never overflow the FIFO.

module psc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_dat,
    output logic             rd_vld
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_rd;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_rd  = rd_en && (count != '0);
    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_rd) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (wr_en && !do_rd) begin
                count <= count + 1'b1;
            end else if (!wr_en && do_rd) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

module param_stream_ctrl #(
    parameter int DATA_WIDTH   = 512,
    parameter int DEPTH        = 32,
    parameter int REPEAT       = 1,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = READ_LATENCY + 2,
    parameter int ADDR_WIDTH   = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_ce,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    output logic                  data_out_last,
    input  logic                  data_out_ready
);
    localparam int CRW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned LAST_PASS = (REPEAT == 0) ? 0 : REPEAT - 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CRW-1:0]          credit;
    logic [31:0]             pass;
    logic [READ_LATENCY-1:0] tag_vld;
    logic [READ_LATENCY-1:0] tag_last;
    logic                    issue;
    logic                    pop;
    logic                    addr_at_end;
    logic                    final_issue;
    logic                    done_q;
    logic                    head_last;

    // Credit covers words in the ROM pipeline plus words buffered, so a full
    // credit count means every FIFO slot is already spoken for.
    assign issue       = (state == RUN) && (credit < CRW'(FIFO_DEPTH));
    assign pop         = data_out_valid && data_out_ready;
    assign addr_at_end = (rom_addr == ADDR_WIDTH'(DEPTH - 1));
    assign final_issue = issue && addr_at_end && (REPEAT != 0) && (pass == 32'(LAST_PASS));

    assign busy          = (state != IDLE);
    assign done          = done_q;
    assign rom_ce        = 1'b1;
    assign data_out_last = data_out_valid && head_last;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (final_issue) state_nxt = DRAIN;
            DRAIN:   if (pop && credit == CRW'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            done_q   <= 1'b0;
            rom_addr <= '0;
            pass     <= '0;
            credit   <= '0;
            tag_vld  <= '0;
            tag_last <= '0;
        end else begin
            state  <= state_nxt;
            done_q <= (state == DRAIN) && (state_nxt == IDLE);

            if (state == IDLE && start) begin
                rom_addr <= '0;
                pass     <= '0;
            end else if (issue) begin
                if (addr_at_end) begin
                    rom_addr <= '0;
                    pass     <= pass + 32'd1;
                end else begin
                    rom_addr <= rom_addr + 1'b1;
                end
            end

            if (issue && !pop) begin
                credit <= credit + 1'b1;
            end else if (!issue && pop) begin
                credit <= credit - 1'b1;
            end

            // Tags ride alongside the ROM pipeline; the oldest stage lines up with rom_q.
            tag_vld[0]  <= issue;
            tag_last[0] <= issue && addr_at_end;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_vld[i]  <= tag_vld[i-1];
                tag_last[i] <= tag_last[i-1];
            end
        end
    end

    psc_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (tag_vld[READ_LATENCY-1]),
        .wr_dat ({tag_last[READ_LATENCY-1], rom_q}),
        .rd_en  (data_out_ready),
        .rd_dat ({head_last, data_out}),
        .rd_vld (data_out_valid)
    );
endmodule
